result_uart_tx: RTL and testbench
=================================

// Module: result_uart_tx
// PURPOSE
//   Downstream stage of the processing unit. It takes one result word plus its
//   overflow flag and sends them back to the host as UART 8N1 (or 8N2) frames.
//   Each message carries the result bytes, least-significant byte first, then
//   one status byte. The block closes the rx -> control -> processing -> tx
//   loop of the warmup top level.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); must be >= 2
//   DATA_W        16   result width in bits; must be a multiple of 8
//   STOP_BITS     1    number of stop bits per byte; only 1 or 2 is allowed
// PORTS
//   clk          in   1       system clock, rising edge
//   rst          in   1       asynchronous, active-low reset
//   in_valid     in   1       result word available
//   in_ready     out  1       block can accept a message
//   in_data      in   DATA_W  result word
//   in_overflow  in   1       overflow flag belonging to in_data
//   tx           out  1       UART serial line, idles high
//   busy         out  1       a message is being shifted out
//   frame_done   out  1       1-cycle pulse when a whole message has been sent
// BEHAVIOUR
//   - Reset (rst=0, takes effect asynchronously): tx=1, in_ready=1, busy=0,
//     frame_done=0, FSM=TX_IDLE, all counters cleared.
//   - Handshake: a message is accepted on a rising edge where
//     in_valid & in_ready = 1.
//     - in_data and in_overflow are captured at that edge.
//     - Later changes on those inputs are ignored.
//     - in_ready = (state == TX_IDLE).
//     - in_valid while busy is ignored; nothing is queued.
//   - Message: NB = DATA_W/8 data bytes, byte 0 = in_data[7:0] first, then a
//     status byte {7'b0, overflow}. Total bytes = NB+1.
//   - Byte frame: one start bit (0), then 8 data bits LSB first, then
//     STOP_BITS stop bits (1). Every bit lasts exactly CLKS_PER_BIT cycles.
//   - FSM transitions:
//     - TX_IDLE -> TX_START on accept.
//     - TX_START -> TX_DATA after 1 bit time.
//     - TX_DATA -> TX_STOP after 8 bit times.
//     - TX_STOP -> TX_START (next byte) or TX_IDLE (after the last byte) once
//       STOP_BITS bit times have elapsed.
//   - Timing:
//     - tx is registered. It falls on the edge after acceptance, so latency is
//       1 cycle.
//     - There is no idle gap between the bytes of one message.
//     - busy is high for exactly (NB+1)*(9+STOP_BITS)*CLKS_PER_BIT cycles.
//   - Completion: on the edge that ends the last stop bit, the FSM returns to
//     TX_IDLE. frame_done=1 and in_ready=1 for that cycle.
//     - If in_valid=1 in that cycle, the next message is accepted.
//     - Its start bit follows with no extra idle time.
//   - Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It restarts at 0 on
//     accept, so bit timing is relative to the accept edge.
//   - Reset mid-message:
//     - tx returns high immediately and the current message is discarded.
//     - After rst is released, the block behaves exactly as after power-up.
//   - Illegal parameters (DATA_W%8 != 0, CLKS_PER_BIT < 2, STOP_BITS not 1/2):
//     elaboration-time $error.
// STRUCTURE
//   - warmup_pkg holds:
//     - tx_state_t enum {TX_IDLE, TX_START, TX_DATA, TX_STOP}
//     - DEFAULT_CLKS_PER_BIT = 434
//     - STATUS_OVF_BIT = 0
//   - Sub-module uart_baud_tick: restartable bit-period counter that emits a
//     one-cycle tick at CLKS_PER_BIT-1. It can be reused by the rx side.
//   - This top holds the FSM, the byte index (0..NB), the bit index (0..7),
//     the stop-bit count, the message shift register and the tx register.
// TESTING  (CLKS_PER_BIT=4 unless stated; the bench UART monitor decodes tx)
//   1. Assert rst=0 mid-simulation -> same cycle: tx=1, in_ready=1, busy=0,
//      frame_done=0.
//   2. DATA_W=16, in_data=16'hA55A, ovf=0, single accept -> bytes 5A, A5, 00.
//      busy for exactly 120 cycles, one frame_done pulse.
//   3. in_data=16'hFFFF, ovf=1 -> bytes FF, FF, 01. Status bit 0 set, other
//      status bits 0.
//   4. in_valid held high with words 16'h1234 then 16'hBEEF -> 34 12 00 34 12
//      00 is wrong: expect 34 12 00 EF BE 00 with no gap. The second accept
//      happens in the frame_done cycle, and in_valid during busy is not
//      accepted.
//   5. rst pulsed low during a data bit of byte 1 -> tx=1 immediately, no
//      frame_done. The next message after release decodes correctly.
//   6. STOP_BITS=2, in_data=16'h00FF -> FF 00 00, each stop period 8 cycles,
//      busy for 132 cycles.

Source files
------------

// File: rtl/warmup_pkg.sv
// Shared types and constants for the warmup result path.
package warmup_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int STATUS_OVF_BIT       = 0;

  function automatic logic [7:0] status_byte(input logic ovf);
    status_byte = 8'(ovf) << STATUS_OVF_BIT;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable bit-period counter: counts 0..CLKS_PER_BIT-1 and ticks on the last count.
module uart_baud_tick
  import warmup_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A restart edge starts a fresh bit period, so it never doubles as a tick.
  assign tick = (cnt_q == LAST) && !restart;

endmodule

// File: rtl/result_uart_tx.sv
// Sends one result word (LSB byte first) plus a status byte as UART 8N1/8N2 frames.
module result_uart_tx
  import warmup_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_overflow,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int NB    = DATA_W / 8;
  localparam int MSG_W = DATA_W + 8;
  localparam int BIW   = (NB > 0) ? $clog2(NB + 1) : 1;

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("result_uart_tx: DATA_W must be a positive multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("result_uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("result_uart_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_t        state_q;
  logic [BIW-1:0]   byte_idx_q;
  logic [2:0]       bit_idx_q;
  logic             stop_cnt_q;
  logic [MSG_W-1:0] msg_q;
  logic             tx_q;
  logic             frame_done_q;
  logic             accept;
  logic             tick;

  assign accept = in_valid && (state_q == TX_IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  // msg_q shifts one bit per data bit, so after 8 shifts the next byte sits at the bottom.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TX_IDLE;
      byte_idx_q   <= '0;
      bit_idx_q    <= '0;
      stop_cnt_q   <= 1'b0;
      msg_q        <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            msg_q      <= {status_byte(in_overflow), in_data};
            byte_idx_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            tx_q      <= msg_q[0];
            bit_idx_q <= '0;
            state_q   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tick) begin
            msg_q <= msg_q >> 1;
            if (bit_idx_q == 3'd7) begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= TX_STOP;
            end else begin
              tx_q      <= msg_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              if (byte_idx_q == BIW'(NB)) begin
                frame_done_q <= 1'b1;
                state_q      <= TX_IDLE;
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
                tx_q       <= 1'b0;
                state_q    <= TX_START;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != TX_IDLE);
  assign in_ready   = (state_q == TX_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench: compares the tx line cycle by cycle against a frame model.
module tb_result_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid1 = 1'b0, ovf1 = 1'b0, valid2 = 1'b0, ovf2 = 1'b0;
  logic [15:0] data1 = '0, data2 = '0;
  logic        ready1, tx1, busy1, fd1;
  logic        ready2, tx2, busy2, fd2;

  int tests_run = 0;
  int tests_failed = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(16), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(valid1), .in_ready(ready1), .in_data(data1),
    .in_overflow(ovf1), .tx(tx1), .busy(busy1), .frame_done(fd1));

  result_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(valid2), .in_ready(ready2), .in_data(data2),
    .in_overflow(ovf2), .tx(tx2), .busy(busy2), .frame_done(fd2));

  function automatic logic get_tx(int s);    return s ? tx2 : tx1;       endfunction
  function automatic logic get_busy(int s);  return s ? busy2 : busy1;   endfunction
  function automatic logic get_fd(int s);    return s ? fd2 : fd1;       endfunction
  function automatic logic get_ready(int s); return s ? ready2 : ready1; endfunction

  // Expected line level per bit period: bytes LSB-first, then {7'b0, ovf}.
  function automatic void build_msg(logic [15:0] w, bit ovf, int stop_bits);
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      b = (i < 2) ? 8'((w >> (8 * i)) & 16'hFF) : {7'b0, ovf};
      exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
      for (int j = 0; j < stop_bits; j++) exp_q.push_back(1'b1);
    end
  endfunction

  task automatic drive(int s, logic v, logic [15:0] w, logic o);
    if (s) begin valid2 = v; data2 = w; ovf2 = o; end
    else   begin valid1 = v; data1 = w; ovf1 = o; end
  endtask

  // Call at the negedge before the accept edge; returns at the first negedge after it.
  task automatic accept_msg(int s, string name, logic [15:0] w, bit ovf, bit hold);
    drive(s, 1'b1, w, ovf);
    tests_run++;
    if (get_ready(s) !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, get_ready(s));
    end
    @(negedge clk);
    drive(s, hold, 16'($urandom), ~ovf);
  endtask

  // Walks the whole message from the cycle after accept, ends in the completion cycle.
  task automatic walk(int s, string name);
    int n = exp_q.size() * CPB;
    int err = 0, bz = 0, fd = 0, first_bad = -1;
    for (int k = 0; k < n; k++) begin
      if (get_tx(s) !== exp_q[k / CPB]) begin
        err++;
        if (first_bad < 0) first_bad = k;
      end
      if (get_busy(s) === 1'b1) bz++;
      if (get_fd(s) === 1'b1) fd++;
      @(negedge clk);
    end
    tests_run++;
    if (err != 0) begin
      tests_failed++;
      $display("FAIL %s tx_waveform: %0d bad cycles (first at %0d), want 0", name, err, first_bad);
    end
    tests_run++;
    if (bz != n) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, bz, n);
    end
    tests_run++;
    if (fd != 0) begin
      tests_failed++;
      $display("FAIL %s early_frame_done: got %0d pulses want 0", name, fd);
    end
    tests_run++;
    if ({get_fd(s), get_busy(s), get_ready(s), get_tx(s)} !== 4'b1011) begin
      tests_failed++;
      $display("FAIL %s completion {fd,busy,ready,tx}: got %b want 1011",
               name, {get_fd(s), get_busy(s), get_ready(s), get_tx(s)});
    end
  endtask

  task automatic check_idle(string name);
    tests_run++;
    if ({tx1, ready1, busy1, fd1} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL %s {tx,ready,busy,fd}: got %b want 1100", name, {tx1, ready1, busy1, fd1});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_single(int s, string name, logic [15:0] w, bit ovf, int stop_bits);
    build_msg(w, ovf, stop_bits);
    accept_msg(s, name, w, ovf, 1'b0);
    walk(s, name);
    @(negedge clk);
    tests_run++;
    if (get_fd(s) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s fd_one_cycle: got %b want 0", name, get_fd(s));
    end
  endtask

  task automatic test_back_to_back();
    build_msg(16'h1234, 1'b0, 1);
    accept_msg(0, "b2b_first", 16'h1234, 1'b0, 1'b1);
    data1 = 16'hBEEF; ovf1 = 1'b0;
    walk(0, "b2b_first");
    @(negedge clk);
    valid1 = 1'b0;
    data1 = 16'h0BAD;
    build_msg(16'hBEEF, 1'b0, 1);
    walk(0, "b2b_second");
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    build_msg(16'hC3A6, 1'b1, 1);
    accept_msg(0, "rst_mid", 16'hC3A6, 1'b1, 1'b0);
    repeat (49) @(negedge clk);
    tests_run++;
    if (busy1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid busy_before_reset: got %b want 1", busy1);
    end
    rst = 1'b0;
    #1;
    check_idle("rst_mid_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ({tx1, ready1, busy1, fd1} !== 4'b1100) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rst_mid quiet_after_release: got %0d bad cycles want 0", bad);
    end
    test_single(0, "rst_mid_next", 16'h5AC3, 1'b0, 1);
  endtask

  task automatic test_random();
    logic [15:0] w;
    bit o;
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      o = 1'($urandom_range(0, 1));
      test_single(0, $sformatf("random%0d", i), w, o, 1);
    end
  endtask

  initial begin
    test_reset();
    test_single(0, "a55a", 16'hA55A, 1'b0, 1);
    test_single(0, "ffff_ovf", 16'hFFFF, 1'b1, 1);
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_single(1, "stop2_00ff", 16'h00FF, 1'b0, 2);
    test_single(1, "stop2_rand", 16'($urandom), 1'b1, 2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
